ahb3lite_sram_slave: RTL

Parametrised AHB-Lite slave that fronts an on-chip SRAM array. It supports full read and write paths with byte, halfword and word transfers, programmable wait states and two-cycle ERROR responses. It replaces the write-only DMA slave/memory pair. It sits on the CPU/DMA AHB-Lite bus behind the decoder, which drives HSEL.

---
 rtl/ahb3lite_sram_slave.sv | 136 +++++++++++++
 1 files changed

// File: rtl/ahb3lite_sram_slave.sv
// AHB-Lite slave in front of an on-chip SRAM array.
// Byte/half/word(/dword) reads and writes, programmable wait states, two-cycle ERROR.
module ahb3lite_sram_slave #(
  parameter int          DATA_W      = 32,
  parameter int          DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic              HWRITE,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [DATA_W-1:0] HRDATA
);

  localparam int NB = DATA_W / 8;
  localparam int LW = $clog2(NB);
  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ERR1 = 2'd2;
  localparam logic [1:0] S_ERR2 = 2'd3;

  logic [1:0]        r_state;
  logic [2:0]        r_cnt;
  logic              r_dp;
  logic              r_wr;
  logic [AW-1:0]     r_idx;
  logic [NB-1:0]     r_mask;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [31:0]       w_off;
  logic [AW-1:0]     w_idx;
  logic [LW-1:0]     w_lane;
  logic              w_acc;
  logic              w_mis;
  logic              w_bad;
  logic              w_good;
  logic              w_err;
  logic              w_done;
  logic [NB-1:0]     w_mask;
  logic [DATA_W-1:0] w_rd;
  logic              w_unused;

  assign w_unused = &{1'b0, HTRANS[0], HBURST};

  assign w_off  = HADDR - BASE_ADDR;
  assign w_idx  = w_off[LW+AW-1:LW];
  assign w_lane = w_off[LW-1:0];
  assign w_acc  = HSEL & HREADY & HTRANS[1];

  always_comb begin
    w_mis  = 1'b0;
    w_mask = '0;
    for (int i = 0; i < LW; i++)
      if (i < int'(HSIZE) && HADDR[i])
        w_mis = 1'b1;
    for (int j = 0; j < NB; j++)
      w_mask[j] = (j >= int'(w_lane)) &&
                  (j < int'(w_lane) + (1 << int'(HSIZE)));
  end

  assign w_bad  = (w_off[31:LW+AW] != '0) ||
                  (HSIZE > 3'(LW)) || w_mis;
  assign w_good = w_acc & ~w_bad;
  assign w_err  = w_acc & w_bad;

  assign HREADYOUT = !((r_state == S_ERR1) ||
                       (r_state == S_WAIT && r_cnt != 3'd0));
  assign HRESP     = (r_state == S_ERR1) || (r_state == S_ERR2);
  assign HRDATA    = r_rdata;
  assign w_done    = r_dp & HREADYOUT;

  // Read issued at accept; a write retiring on the same edge is merged in.
  always_comb begin
    w_rd = r_mem[w_idx];
    if (w_done && r_wr && r_idx == w_idx)
      for (int j = 0; j < NB; j++)
        if (r_mask[j])
          w_rd[8*j +: 8] = HWDATA[8*j +: 8];
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_dp    <= 1'b0;
      r_wr    <= 1'b0;
      r_idx   <= '0;
      r_mask  <= '0;
      r_rdata <= '0;
    end else begin
      if (w_good) begin
        r_dp   <= 1'b1;
        r_wr   <= HWRITE;
        r_idx  <= w_idx;
        r_mask <= w_mask;
        if (!HWRITE)
          r_rdata <= w_rd;
      end else if (w_done) begin
        r_dp <= 1'b0;
      end
      if (r_state == S_ERR1) begin
        r_state <= S_ERR2;
      end else if (r_state == S_WAIT && r_cnt != 3'd0) begin
        r_cnt <= r_cnt - 3'd1;
      end else if (w_err) begin
        r_state <= S_ERR1;
      end else if (w_good && WAIT_STATES > 0) begin
        r_state <= S_WAIT;
        r_cnt   <= 3'(WAIT_STATES);
      end else begin
        r_state <= S_IDLE;
      end
    end
  end

  // Array has no reset; a write still in flight at reset is dropped.
  always_ff @(posedge HCLK) begin
    if (!HRESET && w_done && r_wr)
      for (int j = 0; j < NB; j++)
        if (r_mask[j])
          r_mem[r_idx][8*j +: 8] <= HWDATA[8*j +: 8];
  end

endmodule
